// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, instruction fields, FSM states and ALU status bits
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_LT  = 3'd6,
        OP_LDI = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WB
    } state_e;

    localparam int INSTR_W = 12;
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 7;
    localparam int RS1_MSB = 6;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam int STAT_C  = 1;
    localparam int STAT_LT = 2;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - instruction valid/ready handshake into the sequencer
interface alu_seq_ctrl_if;

    logic                        instr_valid;
    logic                        instr_ready;
    logic [alu_pkg::INSTR_W-1:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 4-entry register file with two operand reads, debug read and paired writes
module alu_regfile #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    rd_addr0,
    output logic [DW-1:0] rd_data0,
    input  logic [1:0]    rd_addr1,
    output logic [DW-1:0] rd_data1,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    input  logic          we0,
    input  logic [1:0]    waddr0,
    input  logic [DW-1:0] wdata0,
    input  logic          we1,
    input  logic [1:0]    waddr1,
    input  logic [DW-1:0] wdata1
);

    logic [DW-1:0] regs [4];

    // Clear on reset; otherwise commit either write port (MUL uses both, never the same entry)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0) begin
                regs[waddr0] <= wdata0;
            end
            if (we1) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - issue/writeback sequencer driving an external registered 4-bit ALU
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus,
    output logic [2:0]    alu_opn,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_out0,
    input  logic [DW-1:0] alu_out1,
    input  logic [DW-1:0] alu_status,
    output logic          flag_c,
    output logic          flag_lt,
    output logic          done,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_e        state;
    op_e           op_q;
    logic [1:0]    rd_q;
    logic [DW-1:0] imm_q;
    logic [CW-1:0] cnt;

    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          we0;
    logic          we1;
    logic [1:0]    waddr0;
    logic [1:0]    waddr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;

    op_e           op_in;
    logic          unused_status;

    assign op_in         = op_e'(bus.instr[OP_MSB:OP_LSB]);
    assign unused_status = ^{alu_status[DW-1:STAT_LT+1], alu_status[STAT_C-1:0]};
    assign bus.instr_ready = (state == ST_IDLE);

    alu_regfile #(.DW(DW)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (bus.instr[RS1_MSB:RS1_LSB]),
        .rd_data0 (rs1_data),
        .rd_addr1 (bus.instr[RS2_MSB:RS2_LSB]),
        .rd_data1 (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1)
    );

    // Writeback decode: only active during WB, MUL's high nibble goes to the next register (wrapping)
    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        waddr0 = rd_q;
        waddr1 = rd_q + 2'd1;
        wdata0 = alu_out0;
        wdata1 = alu_out1;
        if (state == ST_WB) begin
            case (op_q)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: we0 = 1'b1;
                OP_MUL: begin
                    we0 = 1'b1;
                    we1 = 1'b1;
                end
                OP_LDI: begin
                    we0    = 1'b1;
                    wdata0 = imm_q;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: accept in IDLE, wait out ALU latency in ISSUE, commit flags and pulse done in WB
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_ADD;
            rd_q    <= '0;
            imm_q   <= '0;
            cnt     <= '0;
            alu_opn <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            flag_c  <= 1'b0;
            flag_lt <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        op_q  <= op_in;
                        rd_q  <= bus.instr[RD_MSB:RD_LSB];
                        imm_q <= bus.instr[IMM_MSB:IMM_LSB];
                        cnt   <= '0;
                        if (op_in == OP_LDI) begin
                            state <= ST_WB;
                        end else begin
                            alu_opn <= op_in;
                            alu_a   <= rs1_data;
                            alu_b   <= rs2_data;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cnt == CW'(ALU_LAT - 1)) begin
                        state <= ST_WB;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WB: begin
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        flag_c <= alu_status[STAT_C];
                    end
                    if (op_q == OP_LT) begin
                        flag_lt <= alu_status[STAT_LT];
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed and randomized checks of alu_seq_ctrl with a behavioural ALU
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] alu_opn;
    logic [3:0] alu_a, alu_b, alu_out0, alu_out1, alu_status;
    logic       flag_c, flag_lt, done;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int compared   = 0;
    int mismatched = 0;
    int ref_r [4];
    int ref_c;
    int ref_lt;

    always #5 clk = ~clk;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(.ALU_LAT(1), .DW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_opn    (alu_opn),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out0   (alu_out0),
        .alu_out1   (alu_out1),
        .alu_status (alu_status),
        .flag_c     (flag_c),
        .flag_lt    (flag_lt),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    function automatic logic [3:0] alu_lo(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
        case (o)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return {3'b000, a < b};
            default: return 4'd0;
        endcase
    endfunction

    // One-stage registered ALU; status bits irrelevant to the op carry random noise
    always @(posedge clk) begin
        if (rst) begin
            alu_out0   <= 4'd0;
            alu_out1   <= 4'd0;
            alu_status <= 4'd0;
        end else begin
            alu_out0   <= alu_lo(alu_opn, alu_a, alu_b);
            alu_out1   <= 4'((8'(alu_a) * 8'(alu_b)) >> 4);
            alu_status <= {1'($urandom),
                           (alu_opn == 3'd6) ? (alu_a < alu_b) : 1'($urandom),
                           (alu_opn == 3'd0) ? ((5'(alu_a) + 5'(alu_b)) > 5'd15) :
                           (alu_opn == 3'd1) ? (alu_a < alu_b) : 1'($urandom),
                           1'($urandom)};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
        logic [11:0] w;
        w = '0;
        w[11:9] = 3'(op);
        w[8:7]  = 2'(rd);
        if (op == 7) w[3:0] = 4'(imm);
        else begin
            w[6:5] = 2'(rs1);
            w[4:3] = 2'(rs2);
        end
        return w;
    endfunction

    // Architectural effect of one instruction, straight from the op definitions
    task automatic model(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int a, b;
        a = ref_r[rs1];
        b = ref_r[rs2];
        case (op)
            0: begin ref_r[rd] = (a + b) % 16; ref_c = (a + b > 15) ? 1 : 0; end
            1: begin ref_r[rd] = (a - b + 16) % 16; ref_c = (a < b) ? 1 : 0; end
            2: begin ref_r[rd] = (a * b) % 16; ref_r[(rd + 1) % 4] = (a * b) / 16; end
            3: ref_r[rd] = a & b;
            4: ref_r[rd] = a | b;
            5: ref_r[rd] = a ^ b;
            6: ref_lt = (a < b) ? 1 : 0;
            default: ref_r[rd] = imm;
        endcase
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), dbg_data, ref_r[i]);
        end
        chk({tag, "_flag_c"}, flag_c, ref_c);
        chk({tag, "_flag_lt"}, flag_lt, ref_lt);
    endtask

    task automatic run_instr(input string tag, input int op, input int rd, input int rs1, input int rs2, input int imm);
        int n;
        int a, b;
        a = ref_r[rs1];
        b = ref_r[rs2];
        @(negedge clk);
        bus.instr       = enc(op, rd, rs1, rs2, imm);
        bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, bus.instr_ready, 1);
        model(op, rd, rs1, rs2, imm);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 12'($urandom);
        @(negedge clk);
        if (op != 7) begin
            chk({tag, "_alu_opn"}, alu_opn, op);
            chk({tag, "_alu_a"}, alu_a, a);
            chk({tag, "_alu_b"}, alu_b, b);
        end
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, (op == 7) ? 1 : 2);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        check_regs(tag);
    endtask

    initial begin
        int op, rd, rs1, rs2, imm, n;
        int seq_op [5];
        int seq_rd [5];
        int seq_rs1 [5];
        int seq_rs2 [5];
        int seq_imm [5];

        for (int i = 0; i < 4; i++) ref_r[i] = 0;
        ref_c = 0;
        ref_lt = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.instr_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_alu_opn", alu_opn, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        check_regs("reset");

        run_instr("ldi_r0_9", 7, 0, 0, 0, 9);
        run_instr("ldi_r1_8", 7, 1, 0, 0, 8);
        run_instr("add_carry", 0, 2, 0, 1, 0);

        run_instr("ldi_r0_3", 7, 0, 0, 0, 3);
        run_instr("ldi_r1_5", 7, 1, 0, 0, 5);
        run_instr("sub_borrow", 1, 3, 0, 1, 0);
        run_instr("lt_3_5", 6, 0, 0, 1, 0);

        run_instr("ldi_r0_15", 7, 0, 0, 0, 15);
        run_instr("ldi_r1_15", 7, 1, 0, 0, 15);
        run_instr("mul_wrap_rd3", 2, 3, 0, 1, 0);
        run_instr("ldi_r0_6", 7, 0, 0, 0, 6);
        run_instr("ldi_r1_7", 7, 1, 0, 0, 7);
        run_instr("mul_rd1", 2, 1, 0, 1, 0);

        run_instr("ldi_r0_c", 7, 0, 0, 0, 12);
        run_instr("ldi_r1_a", 7, 1, 0, 0, 10);
        run_instr("and_ca", 3, 2, 0, 1, 0);
        run_instr("or_ca", 4, 3, 0, 1, 0);
        run_instr("xor_ca", 5, 2, 0, 1, 0);

        // valid held high: ready must drop while busy and every instruction land exactly once
        seq_op  = '{7, 7, 0, 0, 5};
        seq_rd  = '{0, 1, 0, 0, 2};
        seq_rs1 = '{0, 0, 0, 0, 0};
        seq_rs2 = '{0, 0, 1, 1, 1};
        seq_imm = '{2, 3, 0, 0, 0};
        @(negedge clk);
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.instr = enc(seq_op[k], seq_rd[k], seq_rs1[k], seq_rs2[k], seq_imm[k]);
            n = 0;
            while (!bus.instr_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("held_accept%0d_ready", k), bus.instr_ready, 1);
            model(seq_op[k], seq_rd[k], seq_rs1[k], seq_rs2[k], seq_imm[k]);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("held%0d_busy1", k), bus.instr_ready, 0);
            if (seq_op[k] != 7) begin
                @(negedge clk);
                chk($sformatf("held%0d_busy2", k), bus.instr_ready, 0);
            end
            @(negedge clk);
            chk($sformatf("held%0d_done", k), done, 1);
            chk($sformatf("held%0d_ready_with_done", k), bus.instr_ready, 1);
        end
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check_regs("held");

        for (int k = 0; k < 40; k++) begin
            op  = $urandom_range(7, 0);
            rd  = $urandom_range(3, 0);
            rs1 = $urandom_range(3, 0);
            rs2 = $urandom_range(3, 0);
            imm = $urandom_range(15, 0);
            run_instr($sformatf("rand%0d_op%0d", k, op), op, rd, rs1, rs2, imm);
        end

        // reset while ADD is in ISSUE: abort with no writeback and no done
        run_instr("pre_rst_ldi_r0", 7, 0, 0, 0, 5);
        run_instr("pre_rst_ldi_r1", 7, 1, 0, 0, 6);
        @(negedge clk);
        bus.instr = enc(0, 2, 0, 1, 0);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_issue", bus.instr_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ref_r[i] = 0;
        ref_c = 0;
        ref_lt = 0;
        chk("rst_mid_done", done, 0);
        chk("rst_mid_ready", bus.instr_ready, 1);
        chk("rst_mid_alu_a", alu_a, 0);
        check_regs("rst_mid");
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_late_done", done, 0);
        end
        check_regs("rst_mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
